// File: rtl/wb_trace_buffer_if.sv
// Write-back tap and show-ahead drain port of the trace buffer.
// entry_cyc_o exists only when WB_TRACE_CYC_STAMP_EN is defined.
interface wb_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
`ifdef WB_TRACE_CYC_STAMP_EN
  ,
  parameter int CYC_W  = 16
`endif
);
  logic              wb_en_i;
  logic [ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;
  logic              pop_i;
  logic              entry_valid_o;
  logic [ADDR_W-1:0] entry_addr_o;
  logic [DATA_W-1:0] entry_data_o;
`ifdef WB_TRACE_CYC_STAMP_EN
  logic [CYC_W-1:0]  entry_cyc_o;
`endif

  modport master (
    output wb_en_i,
    output wb_addr_i,
    output wb_data_i,
    output pop_i,
    input  entry_valid_o,
    input  entry_addr_o,
`ifdef WB_TRACE_CYC_STAMP_EN
    input  entry_cyc_o,
`endif
    input  entry_data_o
  );

  modport slave (
    input  wb_en_i,
    input  wb_addr_i,
    input  wb_data_i,
    input  pop_i,
    output entry_valid_o,
    output entry_addr_o,
`ifdef WB_TRACE_CYC_STAMP_EN
    output entry_cyc_o,
`endif
    output entry_data_o
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Write-back trace capture: circular buffer of committed register writes.
// Define WB_TRACE_CYC_STAMP_EN to store a cycle stamp with each entry.
module wb_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 16,
  parameter int CYC_W     = 16,
  parameter int RUN_LIMIT = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm_i,
  input  logic                     wrap_mode_i,
  wb_trace_buffer_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [CYC_W-1:0]         cycle_o,
  output logic                     done_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef WB_TRACE_CYC_STAMP_EN
  localparam int EW = CYC_W + ADDR_W + DATA_W;
`else
  localparam int EW = ADDR_W + DATA_W;
`endif

  localparam logic [CYC_W-1:0] LIM    = CYC_W'(RUN_LIMIT);
  localparam logic [CYC_W-1:0] LIM_M1 = CYC_W'(RUN_LIMIT - 1);
  localparam logic [CW-1:0]    FULL   = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic [CYC_W-1:0] r_cycle;
  logic             r_done;

  logic             w_run;
  logic             w_last;
  logic             w_cap;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_adv;
  logic             w_ovf;
  logic [CW-1:0]    w_cnt_nx;
  logic [CYC_W-1:0] w_cyc_nx;
  logic [EW-1:0]    w_wdata;
  logic [EW-1:0]    w_head;

  assign w_run   = (r_state == S_RUN);
  assign w_last  = (RUN_LIMIT != 0) && (r_cycle == LIM_M1);
  assign w_cap   = w_run & bus.wb_en_i;
  assign w_full  = (r_count == FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = bus.pop_i & ~w_empty;

  // Full without a pop: keep the old data, or evict the oldest in wrap mode.
  assign w_ovf   = w_cap & w_full & ~w_pop;
  assign w_push  = w_cap & (~w_full | w_pop | wrap_mode_i);
  assign w_adv   = w_pop | (w_ovf & wrap_mode_i);

`ifdef WB_TRACE_CYC_STAMP_EN
  assign w_wdata = {r_cycle, bus.wb_addr_i, bus.wb_data_i};
`else
  assign w_wdata = {bus.wb_addr_i, bus.wb_data_i};
`endif

  always_comb begin
    w_state_nx = r_state;
    if (arm_i) begin
      w_state_nx = S_RUN;
    end else begin
      unique case (r_state)
        S_IDLE:  w_state_nx = S_IDLE;
        S_RUN:   w_state_nx = w_last ? S_DONE : S_RUN;
        S_DONE:  w_state_nx = S_DONE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_nx = r_count;
    unique case (1'b1)
      (w_push & ~w_adv): w_cnt_nx = r_count + 1'b1;
      (~w_push & w_adv): w_cnt_nx = r_count - 1'b1;
      default:           w_cnt_nx = r_count;
    endcase
  end

  always_comb begin
    w_cyc_nx = r_cycle;
    if (w_run) begin
      if (w_last)
        w_cyc_nx = LIM;
      else if (!((RUN_LIMIT == 0) && (&r_cycle)))
        w_cyc_nx = r_cycle + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_cycle <= '0;
      r_done  <= 1'b0;
    end else if (arm_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_cycle <= '0;
      r_done  <= 1'b0;
    end else begin
      if (w_push)
        r_wr <= r_wr + 1'b1;
      if (w_adv)
        r_rd <= r_rd + 1'b1;
      r_count <= w_cnt_nx;
      if (w_ovf)
        r_ovf <= 1'b1;
      r_cycle <= w_cyc_nx;
      if (w_run && w_last)
        r_done <= 1'b1;
    end
  end

  // Storage carries no reset; the head is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (w_push && !arm_i)
      r_mem[r_wr] <= w_wdata;
  end

  assign w_head = w_empty ? '0 : r_mem[r_rd];

  assign bus.entry_valid_o = ~w_empty;
  assign bus.entry_data_o  = w_head[DATA_W-1:0];
  assign bus.entry_addr_o  = w_head[DATA_W +: ADDR_W];
`ifdef WB_TRACE_CYC_STAMP_EN
  assign bus.entry_cyc_o   = w_head[DATA_W+ADDR_W +: CYC_W];
`endif

  assign count_o    = r_count;
  assign overflow_o = r_ovf;
  assign cycle_o    = r_cycle;
  assign done_o     = r_done;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: default instance and a DEPTH=4 unlimited one,
// both compared each cycle against a queue-based reference model.
module tb_wb_trace_buffer;

  localparam int IDLE = 0;
  localparam int RUN  = 1;
  localparam int DONE = 2;

  typedef struct packed {
    logic [15:0] c;
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm0, wrap0, arm1, wrap1;
  logic [4:0]  cnt0;
  logic [2:0]  cnt1;
  logic        ovf0, ovf1, done0, done1;
  logic [15:0] cyc0, cyc1;

  int n_tests = 0;
  int n_fail  = 0;

  int          st [2];
  logic [15:0] mc [2];
  logic        mo [2];
  logic        md [2];
  int          dep [2] = '{16, 4};
  int          lim [2] = '{10, 0};
  ent_t        mq0 [$];
  ent_t        mq1 [$];

  always #5 clk = ~clk;

  wb_trace_buffer_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
  wb_trace_buffer_if #(.DATA_W(32), .ADDR_W(5)) if1 ();

  wb_trace_buffer u0 (
    .clk         (clk),
    .rst         (rst),
    .arm_i       (arm0),
    .wrap_mode_i (wrap0),
    .bus         (if0),
    .count_o     (cnt0),
    .overflow_o  (ovf0),
    .cycle_o     (cyc0),
    .done_o      (done0)
  );

  wb_trace_buffer #(.DEPTH(4), .RUN_LIMIT(0)) u1 (
    .clk         (clk),
    .rst         (rst),
    .arm_i       (arm1),
    .wrap_mode_i (wrap1),
    .bus         (if1),
    .count_o     (cnt1),
    .overflow_o  (ovf1),
    .cycle_o     (cyc1),
    .done_o      (done1)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      st[k] = IDLE;
      mc[k] = '0;
      mo[k] = 1'b0;
      md[k] = 1'b0;
    end
    mq0.delete();
    mq1.delete();
  endtask

  task automatic mstep(int k, logic arm, logic wrap, logic en,
                       logic [4:0] a, logic [31:0] d, logic pop);
    ent_t q [$];
    ent_t e;
    logic cap;
    if (k == 0) q = mq0;
    else        q = mq1;
    e.c = mc[k];
    e.a = a;
    e.d = d;
    if (arm) begin
      q.delete();
      mc[k] = '0;
      mo[k] = 1'b0;
      md[k] = 1'b0;
      st[k] = RUN;
    end else begin
      cap = (st[k] == RUN) && en;
      if (st[k] == RUN) begin
        if (lim[k] != 0 && int'(mc[k]) == lim[k] - 1) begin
          st[k] = DONE;
          mc[k] = 16'(lim[k]);
          md[k] = 1'b1;
        end else if (mc[k] != 16'hFFFF) begin
          mc[k] = mc[k] + 16'd1;
        end
      end
      if (pop && q.size() > 0)
        void'(q.pop_front());
      if (cap) begin
        if (q.size() == dep[k]) begin
          mo[k] = 1'b1;
          if (wrap) begin
            void'(q.pop_front());
            q.push_back(e);
          end
        end else begin
          q.push_back(e);
        end
      end
    end
    if (k == 0) mq0 = q;
    else        mq1 = q;
  endtask

  task automatic chk_all(int k);
    ent_t q [$];
    ent_t h;
    if (k == 0) q = mq0;
    else        q = mq1;
    h = (q.size() > 0) ? q[0] : '0;
    if (k == 0) begin
      check("u0_valid", if0.entry_valid_o, q.size() != 0);
      check("u0_addr",  if0.entry_addr_o,  h.a);
      check("u0_data",  if0.entry_data_o,  h.d);
`ifdef WB_TRACE_CYC_STAMP_EN
      check("u0_stamp", if0.entry_cyc_o,   h.c);
`endif
      check("u0_count", cnt0,  q.size());
      check("u0_ovf",   ovf0,  mo[0]);
      check("u0_cycle", cyc0,  mc[0]);
      check("u0_done",  done0, md[0]);
    end else begin
      check("u1_valid", if1.entry_valid_o, q.size() != 0);
      check("u1_addr",  if1.entry_addr_o,  h.a);
      check("u1_data",  if1.entry_data_o,  h.d);
`ifdef WB_TRACE_CYC_STAMP_EN
      check("u1_stamp", if1.entry_cyc_o,   h.c);
`endif
      check("u1_count", cnt1,  q.size());
      check("u1_ovf",   ovf1,  mo[1]);
      check("u1_cycle", cyc1,  mc[1]);
      check("u1_done",  done1, md[1]);
    end
  endtask

  task automatic clear_in();
    arm0 = 1'b0;
    arm1 = 1'b0;
    if0.wb_en_i = 1'b0;
    if0.pop_i   = 1'b0;
    if1.wb_en_i = 1'b0;
    if1.pop_i   = 1'b0;
  endtask

  task automatic step();
    mstep(0, arm0, wrap0, if0.wb_en_i, if0.wb_addr_i,
          if0.wb_data_i, if0.pop_i);
    mstep(1, arm1, wrap1, if1.wb_en_i, if1.wb_addr_i,
          if1.wb_data_i, if1.pop_i);
    @(posedge clk);
    #1;
    chk_all(0);
    chk_all(1);
    clear_in();
  endtask

  task automatic cap0(logic [4:0] a, logic [31:0] d);
    if0.wb_en_i   = 1'b1;
    if0.wb_addr_i = a;
    if0.wb_data_i = d;
  endtask

  task automatic cap1(logic [31:0] d);
    if1.wb_en_i   = 1'b1;
    if1.wb_addr_i = d[4:0];
    if1.wb_data_i = d;
  endtask

  task automatic randomize_in();
    arm0 = ($urandom_range(0, 39) == 0);
    arm1 = ($urandom_range(0, 39) == 0);
    wrap0 = $urandom_range(0, 1) == 1;
    wrap1 = $urandom_range(0, 1) == 1;
    if0.wb_en_i   = $urandom_range(0, 1) == 1;
    if0.wb_addr_i = 5'($urandom_range(0, 31));
    if0.wb_data_i = $urandom;
    if0.pop_i     = $urandom_range(0, 9) < 4;
    if1.wb_en_i   = $urandom_range(0, 1) == 1;
    if1.wb_addr_i = 5'($urandom_range(0, 31));
    if1.wb_data_i = $urandom;
    if1.pop_i     = $urandom_range(0, 9) < 4;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    wrap0 = 1'b0;
    wrap1 = 1'b0;
    if0.wb_addr_i = '0;
    if0.wb_data_i = '0;
    if1.wb_addr_i = '0;
    if1.wb_data_i = '0;
    clear_in();
    model_reset();
    #1 rst = 1'b0;
    #1;
    chk_all(0);
    chk_all(1);
    #20 rst = 1'b1;
    @(posedge clk);
    #1;

    // Writes before arming are ignored.
    cap0(5'd7, 32'h77);
    cap1(32'h9);
    step();

    arm0 = 1'b1;
    step();
    cap0(5'd3, 32'h0000_00AA);
    step();
    step();
    cap0(5'd4, 32'h0000_00BB);
    step();
    check("t1_count", cnt0, 2);
    repeat (7) step();
    check("t1_done",  done0, 1);
    check("t1_cycle", cyc0, 10);
    check("t1_a0", if0.entry_addr_o, 3);
    check("t1_d0", if0.entry_data_o, 32'hAA);
`ifdef WB_TRACE_CYC_STAMP_EN
    check("t1_s0", if0.entry_cyc_o, 0);
`endif
    if0.pop_i = 1'b1;
    step();
    check("t1_a1", if0.entry_addr_o, 4);
    check("t1_d1", if0.entry_data_o, 32'hBB);
`ifdef WB_TRACE_CYC_STAMP_EN
    check("t1_s1", if0.entry_cyc_o, 2);
`endif
    if0.pop_i = 1'b1;
    step();
    check("t1_empty", if0.entry_valid_o, 0);

    for (int w = 0; w < 2; w++) begin
      wrap1 = (w == 1);
      arm1 = 1'b1;
      step();
      for (int i = 1; i <= 6; i++) begin
        cap1(32'(i));
        step();
      end
      check("t2_count", cnt1, 4);
      check("t2_ovf",   ovf1, 1);
      for (int i = 1; i <= 4; i++) begin
        check("t2_head", if1.entry_data_o, (w == 1) ? i + 2 : i);
        if1.pop_i = 1'b1;
        step();
      end
    end

    wrap1 = 1'b0;
    arm1 = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      cap1(32'(i));
      step();
    end
    cap1(32'd5);
    if1.pop_i = 1'b1;
    step();
    check("t4_count", cnt1, 4);
    check("t4_ovf",   ovf1, 0);
    check("t4_head",  if1.entry_data_o, 2);
    repeat (5) begin
      if1.pop_i = 1'b1;
      step();
    end
    check("t4_empty", cnt1, 0);

    arm0 = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      cap0(5'(i), 32'(i + 100));
      step();
    end
    guard = 0;
    while (!done0 && guard < 20) begin
      step();
      guard++;
    end
    check("t5_done", done0, 1);
    check("t5_count", cnt0, 3);
    arm0 = 1'b1;
    if0.pop_i = 1'b1;
    cap0(5'd9, 32'h99);
    step();
    check("t5_acount", cnt0, 0);
    check("t5_acycle", cyc0, 0);
    check("t5_adone",  done0, 0);
    cap0(5'd1, 32'h11);
    step();
    check("t5_run", cnt0, 1);

    repeat (1500) begin
      randomize_in();
      step();
    end

    arm0 = 1'b1;
    arm1 = 1'b1;
    step();
    repeat (3) begin
      cap0(5'd2, 32'h22);
      cap1(32'h33);
      step();
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk_all(0);
    chk_all(1);
    #3 rst = 1'b1;
    cap0(5'd2, 32'h22);
    cap1(32'h33);
    step();
    check("t6_idle0", cnt0, 0);
    check("t6_idle1", cnt1, 0);

    repeat (1500) begin
      randomize_in();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Synthesizable writeback trace capture unit for the core pipeline. It taps the write-back stage's enable/register-address/data outputs and records each committed register write into a parametrised circular buffer. A bounded run counter raises `done_o` after a programmed number of cycles. The buffer is drained through a show-ahead pop interface, so benches and on-chip debug logic can inspect the register-write history without probing hierarchy.

## Interface
- `DATA_W`, 32, width of write-back data
- `ADDR_W`, 5, width of destination register address
- `DEPTH`, 16, buffer entries; power of two, at least 2
- `CYC_W`, 16, width of the cycle counter and cycle stamps
- `RUN_LIMIT`, 10, cycles per run; 0 = unlimited
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `arm_i`  in  1  start or restart a run; clears buffer, counter and overflow
- `wrap_mode_i`  in  1  1 = overwrite oldest entry when full; 0 = drop new entries when full
- `wb_en_i`  in  1  write-back enable from the WB stage
- `wb_addr_i`  in  ADDR_W  destination register address
- `wb_data_i`  in  DATA_W  write-back data
- `pop_i`  in  1  remove the oldest entry
- `entry_valid_o`  out  1  buffer non-empty
- `entry_addr_o`  out  ADDR_W  oldest entry's register address
- `entry_data_o`  out  DATA_W  oldest entry's data
- `entry_cyc_o`  out  CYC_W  oldest entry's cycle stamp; present only with `WB_TRACE_CYC_STAMP_EN`
- `count_o`  out  $clog2(DEPTH)+1  number of stored entries
- `overflow_o`  out  1  sticky; set when an entry was dropped or overwritten
- `cycle_o`  out  CYC_W  cycles elapsed in the current run
- `done_o`  out  1  run limit reached

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values: all outputs 0, pointers 0, state IDLE.
- IDLE: `wb_en_i` is ignored. `arm_i` moves to RUN.
- `arm_i` in any state does the following on that edge, and takes priority over any pop or capture in the same cycle:
  - count = 0 and both pointers = 0;
  - `cycle_o` = 0, `overflow_o` = 0, `done_o` = 0;
  - state = RUN.
- RUN:
  - `cycle_o` increments by 1 every cycle.
  - When `RUN_LIMIT` != 0 and `cycle_o` == `RUN_LIMIT`-1, the FSM goes to DONE on that edge, `cycle_o` becomes `RUN_LIMIT` and `done_o` = 1.
  - A capture in that final cycle is still recorded.
  - With `RUN_LIMIT` = 0, the counter saturates at all-ones and the run never ends.
- DONE: no capture and the counter is frozen. Pops are still served. `done_o` holds until `arm_i` or reset.
- Capture occurs in RUN when `wb_en_i` = 1. Writes to address 0 are recorded like any other.
- Pop: when `pop_i` = 1 and the buffer is non-empty, the oldest entry is removed. `pop_i` on an empty buffer is ignored.
- Full buffer, capture without pop:
  - `wrap_mode_i` = 0: the new entry is dropped, count stays `DEPTH`, `overflow_o` is set.
  - `wrap_mode_i` = 1: the oldest entry is discarded, the new entry is appended, count stays `DEPTH`, `overflow_o` is set.
- Full buffer, capture with pop: both occur, count is unchanged, no overflow.
- Empty buffer, capture with pop: the pop is ignored and the capture is stored (count becomes 1).
- Pointers wrap modulo `DEPTH`.
- `wrap_mode_i` is sampled each cycle and may change mid-run.

## Timing
- Capture latency is 1: a `wb_en_i` sampled at edge N appears in `count_o` after edge N. If the buffer was empty, it also appears on `entry_*` after edge N.
- Outputs are show-ahead: `entry_*` always shows the oldest entry. The outputs are registered or read from a flop array; there is no combinational path from `pop_i` or `wb_*` to `entry_*`.
- After a pop at edge N, the next-oldest entry is on `entry_*` after edge N.
- `count_o`, `overflow_o`, `cycle_o` and `done_o` are registered and update on the same edge as the event that changes them.
- Asserting `rst` mid-run clears everything immediately, without waiting for `clk`.

## Configuration
- `WB_TRACE_CYC_STAMP_EN` defined:
  - each entry also stores the `cycle_o` value at its capture edge, before the increment;
  - the stamp is presented on `entry_cyc_o`;
  - entry width is ADDR_W+DATA_W+CYC_W.
- `WB_TRACE_CYC_STAMP_EN` undefined:
  - the `entry_cyc_o` port and its storage are absent;
  - entry width is ADDR_W+DATA_W;
  - all other behaviour is identical.

## Test plan
- Defaults; reset, arm, then `wb_en_i`=1 with addr 3 / data 0x0000_00AA in cycle 0 and addr 4 / data 0x0000_00BB in cycle 2 -> `count_o`=2. Pops return (3, 0xAA) then (4, 0xBB). With the macro, the stamps are 0 then 2. `done_o`=1 and `cycle_o`=10 after the 10th edge.
- `DEPTH`=4, `RUN_LIMIT`=0, `wrap_mode_i`=0, 6 consecutive captures with data 1..6 -> `count_o`=4, `overflow_o`=1, buffer holds 1..4.
- Same as above but `wrap_mode_i`=1 -> buffer holds 3..6, `overflow_o`=1.
- `DEPTH`=4, buffer full: capture and pop in the same cycle -> count stays 4, `overflow_o`=0, the oldest entry advances by one. Pop on an empty buffer -> no change.
- In DONE with 3 entries, assert `arm_i` together with `pop_i` and `wb_en_i` -> `count_o`=0, `cycle_o`=0, `done_o`=0, state RUN, and the capture in that cycle is not recorded.
- Mid-run, drop `rst` asynchronously between clock edges -> all outputs go to 0 at once; after release, `wb_en_i` is ignored until `arm_i`.
